// File: rtl/layer_bridge_fifo.sv
// Multi-channel inter-layer FIFO with valid/ready on both sides, selectable
// registered or first-word-fall-through read, occupancy and sticky status flags.
module layer_bridge_fifo #(
    parameter int CH        = 4,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int FWFT      = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        wr_valid,
    input  logic signed [DATA_W-1:0]    wr_data [0:CH-1],
    output logic                        wr_ready,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic signed [DATA_W-1:0]    rd_data [0:CH-1],
    output logic                        rd_strobe,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic [$clog2(DEPTH+1)-1:0]  max_count,
    output logic                        almost_full,
    output logic                        overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = CH * DATA_W;

    logic [EW-1:0] mem [0:DEPTH-1];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [CW-1:0] max_count_reg;
    logic          overflow_reg;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] wr_word;
    logic [EW-1:0] rd_word;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_chan
            assign wr_word[gi*DATA_W +: DATA_W] = wr_data[gi];
            assign rd_data[gi]                  = rd_word[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign full        = (count_reg == CW'(DEPTH));
    assign empty       = (count_reg == '0);
    assign wr_ready    = !full;
    assign rd_valid    = !empty;
    assign almost_full = (count_reg >= CW'(AF_THRESH));
    assign count       = count_reg;
    assign max_count   = max_count_reg;
    assign overflow    = overflow_reg;

    // Transfers are suppressed while reset or flush is active so that neither
    // the storage nor the read register sees a phantom handshake.
    assign push = wr_valid && !full && reset && !flush;
    assign pop  = rd_ready && !empty && reset && !flush;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            max_count_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
            if (count_next > max_count_reg) begin
                max_count_reg <= count_next;
            end
            if (wr_valid && full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry shown directly; zeros when empty keep the bus quiet.
            assign rd_word   = empty ? '0 : mem[rd_ptr_reg];
            assign rd_strobe = pop;
        end else begin : g_registered
            logic [EW-1:0] rd_word_reg;
            logic          rd_strobe_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    rd_word_reg   <= '0;
                    rd_strobe_reg <= 1'b0;
                end else begin
                    rd_strobe_reg <= pop;
                    if (pop) begin
                        rd_word_reg <= mem[rd_ptr_reg];
                    end
                end
            end

            assign rd_word   = rd_word_reg;
            assign rd_strobe = rd_strobe_reg;
        end
    endgenerate

endmodule

// File: tb/tb_layer_bridge_fifo.sv
// Drives a registered-read and an FWFT instance with identical traffic and
// checks both every cycle against a queue-based model of the FIFO.
module tb_layer_bridge_fifo;

    localparam int CH    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AF    = 2;
    localparam int CW    = 3;
    localparam int EW    = CH * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset    = 1'b0;
    logic flush    = 1'b0;
    logic wr_valid = 1'b0;
    logic rd_ready = 1'b0;
    logic signed [DW-1:0] wr_data [0:CH-1];

    logic wr_ready0, rd_valid0, rd_strobe0, almost_full0, overflow0;
    logic wr_ready1, rd_valid1, rd_strobe1, almost_full1, overflow1;
    logic [CW-1:0] count0, max_count0, count1, max_count1;
    logic signed [DW-1:0] rd_data0 [0:CH-1];
    logic signed [DW-1:0] rd_data1 [0:CH-1];

    layer_bridge_fifo #(.CH(CH), .DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .FWFT(0)) u_reg (
        .clk(clk), .reset(reset), .flush(flush),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready0),
        .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_data(rd_data0),
        .rd_strobe(rd_strobe0), .count(count0), .max_count(max_count0),
        .almost_full(almost_full0), .overflow(overflow0)
    );

    layer_bridge_fifo #(.CH(CH), .DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .flush(flush),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready1),
        .rd_valid(rd_valid1), .rd_ready(rd_ready), .rd_data(rd_data1),
        .rd_strobe(rd_strobe1), .count(count1), .max_count(max_count1),
        .almost_full(almost_full1), .overflow(overflow1)
    );

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_miss = 0;

    // Reference model: contents as a queue, plus the registered read outputs.
    logic [EW-1:0] q [$];
    int            m_max  = 0;
    bit            m_ovf  = 0;
    logic [EW-1:0] m_rd   = '0;
    bit            m_strb = 0;

    function automatic logic [EW-1:0] mk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic logic [EW-1:0] pack_in();
        logic [EW-1:0] v;
        for (int c = 0; c < CH; c++) v[c*DW +: DW] = wr_data[c];
        return v;
    endfunction

    function automatic logic [EW-1:0] pack_rd0();
        logic [EW-1:0] v;
        for (int c = 0; c < CH; c++) v[c*DW +: DW] = rd_data0[c];
        return v;
    endfunction

    function automatic logic [EW-1:0] pack_rd1();
        logic [EW-1:0] v;
        for (int c = 0; c < CH; c++) v[c*DW +: DW] = rd_data1[c];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit full;
        bit do_pop;
        bit do_push;
        logic [EW-1:0] wd;
        wd = pack_in();
        if (!reset) begin
            q.delete();
            m_max  = 0;
            m_ovf  = 0;
            m_rd   = '0;
            m_strb = 0;
        end else if (flush) begin
            q.delete();
            m_max  = 0;
            m_ovf  = 0;
            m_strb = 0;
        end else begin
            full    = (q.size() == DEPTH);
            do_pop  = rd_ready && (q.size() > 0);
            do_push = wr_valid && !full;
            if (wr_valid && full) m_ovf = 1;
            m_strb = do_pop;
            if (do_pop) m_rd = q.pop_front();
            if (do_push) q.push_back(wd);
            if (q.size() > m_max) m_max = q.size();
        end
    end

    task automatic check_one(input string tag, input logic [CW-1:0] cnt, input logic [CW-1:0] mx,
                             input logic wrr, input logic rdv, input logic af, input logic ov,
                             input logic st, input logic [EW-1:0] rd, input bit fwft);
        chk({tag, " count"}, 64'(cnt), 64'(q.size()));
        chk({tag, " max_count"}, 64'(mx), 64'(m_max));
        chk({tag, " wr_ready"}, 64'(wrr), 64'(q.size() < DEPTH));
        chk({tag, " rd_valid"}, 64'(rdv), 64'(q.size() > 0));
        chk({tag, " almost_full"}, 64'(af), 64'(q.size() >= AF));
        chk({tag, " overflow"}, 64'(ov), 64'(m_ovf));
        if (!fwft) begin
            chk({tag, " rd_data"}, 64'(rd), 64'(m_rd));
            chk({tag, " rd_strobe"}, 64'(st), 64'(m_strb));
        end else begin
            if (q.size() > 0) chk({tag, " rd_data"}, 64'(rd), 64'(q[0]));
            if (reset && !flush)
                chk({tag, " rd_strobe"}, 64'(st), 64'((q.size() > 0) && rd_ready));
        end
    endtask

    always @(negedge clk) begin
        #2;
        check_one("reg", count0, max_count0, wr_ready0, rd_valid0, almost_full0,
                  overflow0, rd_strobe0, pack_rd0(), 0);
        check_one("fwft", count1, max_count1, wr_ready1, rd_valid1, almost_full1,
                  overflow1, rd_strobe1, pack_rd1(), 1);
    end

    task automatic drive(input logic rs, input logic fl, input logic wv, input logic rr,
                         input logic [EW-1:0] d);
        @(negedge clk);
        reset    = rs;
        flush    = fl;
        wr_valid = wv;
        rd_ready = rr;
        for (int c = 0; c < CH; c++) wr_data[c] = d[c*DW +: DW];
        n_vec++;
    endtask

    initial begin
        for (int c = 0; c < CH; c++) wr_data[c] = '0;

        // Reset held for two cycles, then idle.
        drive(0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, '0);
        drive(1, 0, 0, 0, '0);
        #3;
        chk("lit reset count", 64'(count0), 64'(0));
        chk("lit reset wr_ready", 64'(wr_ready0), 64'(1));
        chk("lit reset rd_valid", 64'(rd_valid0), 64'(0));
        chk("lit reset rd_data", 64'(pack_rd0()), 64'(0));

        // Fill to full.
        drive(1, 0, 1, 0, mk(1, 2, 3, 4));
        drive(1, 0, 1, 0, mk(5, 6, 7, 8));
        drive(1, 0, 1, 0, mk(9, 10, 11, 12));
        #3;
        chk("lit af after 2 pushes", 64'(almost_full0), 64'(1));
        drive(1, 0, 1, 0, mk(13, 14, 15, 16));
        drive(1, 0, 0, 0, '0);
        #3;
        chk("lit fill count", 64'(count0), 64'(4));
        chk("lit fill wr_ready", 64'(wr_ready0), 64'(0));

        // Drain.
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, '0);
        drive(1, 0, 0, 0, '0);
        #3;
        chk("lit drain last strobe", 64'(rd_strobe0), 64'(1));
        chk("lit drain last data", 64'(pack_rd0()), 64'(mk(13, 14, 15, 16)));
        chk("lit drain max_count", 64'(max_count0), 64'(4));
        drive(1, 0, 0, 0, '0);

        // FWFT latency.
        drive(1, 0, 1, 0, mk(-1, -2, -3, -4));
        drive(1, 0, 0, 0, '0);
        #3;
        chk("lit fwft rd_valid", 64'(rd_valid1), 64'(1));
        chk("lit fwft rd_data", 64'(pack_rd1()), 64'(mk(-1, -2, -3, -4)));
        drive(1, 0, 0, 1, '0);
        #3;
        chk("lit fwft strobe", 64'(rd_strobe1), 64'(1));
        drive(1, 0, 0, 0, '0);
        #3;
        chk("lit fwft empty", 64'(rd_valid1), 64'(0));

        // Overflow with concurrent pop.
        for (int k = 1; k <= 4; k++) drive(1, 0, 1, 0, mk(k, k, k, k));
        drive(1, 0, 1, 1, mk(99, 99, 99, 99));
        drive(1, 0, 0, 0, '0);
        #3;
        chk("lit overflow set", 64'(overflow0), 64'(1));
        chk("lit overflow count", 64'(count0), 64'(3));
        drive(1, 0, 0, 0, '0);

        // Flush together with a write.
        drive(1, 1, 1, 0, mk(7, 7, 7, 7));
        drive(1, 0, 0, 0, '0);
        #3;
        chk("lit flush count", 64'(count0), 64'(0));
        chk("lit flush max_count", 64'(max_count0), 64'(0));
        chk("lit flush overflow", 64'(overflow0), 64'(0));

        // Streaming across pointer wrap.
        drive(1, 0, 1, 0, mk(1, 1, 1, 1));
        drive(1, 0, 1, 0, mk(2, 2, 2, 2));
        for (int k = 3; k < 23; k++) drive(1, 0, 1, 1, mk(k, k, k, k));
        drive(1, 0, 0, 0, '0);
        #3;
        chk("lit wrap count", 64'(count0), 64'(2));
        chk("lit wrap max_count", 64'(max_count0), 64'(2));

        // Randomised traffic in phases biased toward filling or draining.
        for (int i = 0; i < 800; i++) begin
            logic rs, fl, wv, rr;
            logic [EW-1:0] d;
            bit fill_phase;
            fill_phase = ((i / 40) % 2) == 0;
            rs = ($urandom_range(0, 149) != 0);
            fl = ($urandom_range(0, 59) == 0);
            wv = fill_phase ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            rr = fill_phase ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            d  = {$urandom(), $urandom()};
            drive(rs, fl, wv, rr, d);
        end

        // Reset mid-stream, together with flush.
        drive(1, 0, 1, 0, mk(3, 1, 4, 1));
        drive(1, 0, 1, 1, mk(5, 9, 2, 6));
        drive(1, 0, 1, 0, mk(5, 3, 5, 8));
        drive(0, 1, 1, 1, mk(9, 7, 9, 3));
        drive(1, 0, 0, 0, '0);
        #3;
        chk("lit midreset count", 64'(count0), 64'(0));
        chk("lit midreset rd_data", 64'(pack_rd0()), 64'(0));
        chk("lit midreset max_count", 64'(max_count0), 64'(0));
        drive(1, 0, 0, 0, '0);
        @(negedge clk);
        #4;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/layer_bridge_fifo.md
Name: layer_bridge_fifo

Overview:
Parametrised multi-channel FIFO placed between two conv layers in the CNN pipeline. It generalises the fixed 4×16-bit inter-layer bridge to configurable channel count, data width and depth. It adds valid/ready handshake on both sides, a selectable read mode (registered or first-word-fall-through), and an almost-full early back-pressure flag. It also provides an occupancy count, a high-water mark, a sticky overflow flag and a synchronous flush.

Parameters:
CH, 4, channels carried per entry (one pixel per output feature map)
DATA_W, 16, signed width of each channel word
DEPTH, 8, entries; power of two, >= 2
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
FWFT, 0, 0 = registered read (1-cycle latency), 1 = first-word-fall-through

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
flush  in  1  synchronous clear of contents (active-high)
wr_valid  in  1  producer has an entry
wr_data  in  CH x signed DATA_W  entry to store (unpacked array [0:CH-1])
wr_ready  out  1  FIFO can accept (= !full)
rd_valid  out  1  FIFO has an entry available (= !empty)
rd_ready  in  1  consumer accepts
rd_data  out  CH x signed DATA_W  output entry
rd_strobe  out  1  rd_data holds a newly popped entry this cycle
count  out  $clog2(DEPTH+1)  current occupancy
max_count  out  $clog2(DEPTH+1)  high-water mark since reset/flush
almost_full  out  1  count >= AF_THRESH
overflow  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (reset==0 at a clk edge): pointers, count, max_count = 0. overflow = 0, rd_data = all zeros, rd_strobe = 0. Resulting outputs: wr_ready = 1, rd_valid = 0, almost_full = 0. Reset mid-traffic discards all contents; reset has priority over flush and all transfers.
- Push = wr_valid && wr_ready. Pop = rd_valid && rd_ready.
- wr_ready depends only on registered state (no comb path from rd_ready). A full FIFO refuses a write even if a pop occurs in the same cycle.
- Write while full: the entry is discarded, overflow sets and holds until reset/flush, and count is unchanged. Producers that cannot stall (layer pulses) must gate on almost_full.
- Read while empty: no effect. rd_strobe = 0 and no flag is set.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. full/empty are derived from count.
- count: +1 on push only, -1 on pop only, otherwise held.
- max_count updates to the next-cycle count whenever that value exceeds the current max_count.
- FWFT=0: rd_data is a register loaded with the head entry on the edge that pops it. rd_strobe = 1 in the following cycle (one-cycle latency). rd_data holds its value otherwise.
- FWFT=1: rd_data combinationally shows the head entry whenever rd_valid = 1, and is don't-care when empty. rd_strobe = Pop in the same cycle (zero latency).
- Empty FIFO with a push: in FWFT=1, rd_valid rises the next cycle (no write-through to a same-cycle read).
- flush (with reset = 1): pointers, count and max_count go to 0 and overflow clears. A push or pop in the same cycle is ignored. rd_data is not cleared. rd_strobe = 0 the next cycle in both modes.
- Channel words are stored and returned bit-exact; there is no arithmetic on data.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles, then release -> wr_ready=1, rd_valid=0, count=0, max_count=0, overflow=0, rd_data={0,0,0,0}.
- Fill and drain, DEPTH=4, FWFT=0: push {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16} -> after 4th push count=4, wr_ready=0, almost_full=1 (AF_THRESH=2 rises after 2nd push). Pop 4 with rd_ready=1 -> rd_strobe pulses one cycle after each pop with entries in order; final count=0, max_count=4.
- FWFT=1 latency: push {-1,-2,-3,-4} into empty FIFO -> next cycle rd_valid=1 and rd_data={-1,-2,-3,-4} with no pop. Assert rd_ready -> rd_strobe=1 in the same cycle and rd_valid=0 the next.
- Overflow: fill DEPTH=4, then assert wr_valid with {99,99,99,99} while rd_ready=1 -> write refused, overflow=1 sticky, count=3 after the pop. 99 never appears on rd_data.
- Wrap-around with concurrency: stream 20 entries (value k in all channels) with wr_valid=1 and rd_ready=1 continuously from count=2 -> count stays 2, output order is preserved across pointer wrap, and max_count never exceeds 3.
- Flush vs reset: with count=3 and overflow=1, pulse flush together with wr_valid -> next cycle count=0, max_count=0, overflow=0, and the write is not stored. Then drop reset mid-stream -> all state is zero the next cycle regardless of flush.
